// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR-feedback LFSR pattern generator and its checker.
// The feedback tap table lives here so generator and checker cannot disagree on it.
package lfsr_pkg;

    // Checker FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Tap mask (bit k set means register bit k, 0-based, is a feedback tap)
    // for an LFSR of length num_bits. Lengths outside 3..32 have no taps.
    function automatic logic [31:0] lfsr_tap_mask(input int num_bits);
        logic [31:0] mask_s;
        case (num_bits)
            32'sd3:  mask_s = 32'h0000_0006;
            32'sd4:  mask_s = 32'h0000_000C;
            32'sd5:  mask_s = 32'h0000_0014;
            32'sd6:  mask_s = 32'h0000_0030;
            32'sd7:  mask_s = 32'h0000_0060;
            32'sd8:  mask_s = 32'h0000_00B8;
            32'sd9:  mask_s = 32'h0000_0110;
            32'sd10: mask_s = 32'h0000_0240;
            32'sd11: mask_s = 32'h0000_0500;
            32'sd12: mask_s = 32'h0000_0829;
            32'sd13: mask_s = 32'h0000_100D;
            32'sd14: mask_s = 32'h0000_2015;
            32'sd15: mask_s = 32'h0000_6000;
            32'sd16: mask_s = 32'h0000_D008;
            32'sd17: mask_s = 32'h0001_2000;
            32'sd18: mask_s = 32'h0002_0400;
            32'sd19: mask_s = 32'h0004_0023;
            32'sd20: mask_s = 32'h0009_0000;
            32'sd21: mask_s = 32'h0014_0000;
            32'sd22: mask_s = 32'h0030_0000;
            32'sd23: mask_s = 32'h0042_0000;
            32'sd24: mask_s = 32'h00E1_0000;
            32'sd25: mask_s = 32'h0120_0000;
            32'sd26: mask_s = 32'h0200_0023;
            32'sd27: mask_s = 32'h0400_0013;
            32'sd28: mask_s = 32'h0900_0000;
            32'sd29: mask_s = 32'h1400_0000;
            32'sd30: mask_s = 32'h2000_0029;
            32'sd31: mask_s = 32'h4800_0000;
            32'sd32: mask_s = 32'h8020_0003;
            default: mask_s = 32'h0000_0000;
        endcase
        return mask_s;
    endfunction

    // Feedback bit: XNOR of all tap bits, i.e. the inverted parity of the tapped bits.
    function automatic logic lfsr_fb(input logic [31:0] w, input int num_bits);
        return ~(^(w & lfsr_tap_mask(num_bits)));
    endfunction

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over a same-cycle increment.
module sat_counter
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;

    // Next count: clear first, then a non-wrapping increment
    always_comb begin
        count_s = count_r;
        if (clr) begin
            count_s = {WIDTH{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_s = count_r + CNT_ONE;
        end else begin
            count_s = count_r;
        end
    end

    // Counter register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            count_r <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronises to the XNOR LFSR generator's word stream, then
// checks every valid word against a free-running local prediction and reports
// lock status, per-word error pulses and saturating error/word counters.
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS     = 8,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4,
    parameter int ERR_WIDTH    = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Enable,
    input  logic [NUM_BITS-1:0]  i_Data,
    input  logic                 i_Clear,
    output logic                 o_Locked,
    output logic                 o_Error,
    output logic [ERR_WIDTH-1:0] o_Err_Count,
    output logic [CNT_WIDTH-1:0] o_Word_Count
);

    // Run counters are sized to hold their terminal value, so they never wrap
    localparam int MR_W = $clog2(LOCK_COUNT) + 1;
    localparam int ER_W = $clog2(UNLOCK_COUNT) + 1;

    localparam logic [MR_W-1:0]     MR_ZERO  = {MR_W{1'b0}};
    localparam logic [MR_W-1:0]     MR_ONE   = MR_W'(1);
    localparam logic [MR_W-1:0]     MR_LAST  = MR_W'(LOCK_COUNT - 1);
    localparam logic [MR_W-1:0]     MR_FULL  = MR_W'(LOCK_COUNT);
    localparam logic [ER_W-1:0]     ER_ZERO  = {ER_W{1'b0}};
    localparam logic [ER_W-1:0]     ER_ONE   = ER_W'(1);
    localparam logic [ER_W-1:0]     ER_LAST  = ER_W'(UNLOCK_COUNT - 1);
    localparam logic [ER_W-1:0]     ER_FULL  = ER_W'(UNLOCK_COUNT);
    localparam logic [NUM_BITS-1:0] ALL_ONES = {NUM_BITS{1'b1}};
    localparam logic [NUM_BITS-1:0] WORD_ZERO = {NUM_BITS{1'b0}};

    state_t              state_r;
    state_t              state_s;
    logic [NUM_BITS-1:0] prev_r;
    logic [NUM_BITS-1:0] prev_s;
    logic [MR_W-1:0]     match_run_r;
    logic [MR_W-1:0]     match_run_s;
    logic [ER_W-1:0]     err_run_r;
    logic [ER_W-1:0]     err_run_s;
    logic                locked_r;
    logic                error_r;

    logic [NUM_BITS-1:0] exp_s;
    logic                match_s;
    logic                err_inc_s;
    logic                word_inc_s;

    // Prediction of the current word from the previous one; the all-ones
    // lock-up word is never accepted as a match
    always_comb begin
        exp_s   = {prev_r[NUM_BITS-2:0], lfsr_fb(32'(prev_r), NUM_BITS)};
        match_s = (i_Data == exp_s) && (i_Data != ALL_ONES);
    end

    // Next-state logic: acquisition re-syncs to each received word, lock free-runs
    always_comb begin
        state_s     = state_r;
        prev_s      = prev_r;
        match_run_s = match_run_r;
        err_run_s   = err_run_r;
        err_inc_s   = 1'b0;
        word_inc_s  = 1'b0;
        if (i_Enable) begin
            case (state_r)
                IDLE: begin
                    prev_s      = i_Data;
                    match_run_s = MR_ZERO;
                    state_s     = ACQUIRE;
                end
                ACQUIRE: begin
                    prev_s = i_Data;
                    if (match_s) begin
                        if (match_run_r == MR_LAST) begin
                            match_run_s = MR_FULL;
                            err_run_s   = ER_ZERO;
                            state_s     = LOCKED;
                        end else begin
                            match_run_s = match_run_r + MR_ONE;
                        end
                    end else begin
                        match_run_s = MR_ZERO;
                    end
                end
                LOCKED: begin
                    prev_s     = exp_s;
                    word_inc_s = 1'b1;
                    if (match_s) begin
                        err_run_s = ER_ZERO;
                    end else begin
                        err_inc_s = 1'b1;
                        if (err_run_r == ER_LAST) begin
                            err_run_s   = ER_FULL;
                            match_run_s = MR_ZERO;
                            prev_s      = i_Data;
                            state_s     = ACQUIRE;
                        end else begin
                            err_run_s = err_run_r + ER_ONE;
                        end
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, history and registered status outputs
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_r     <= IDLE;
            prev_r      <= WORD_ZERO;
            match_run_r <= MR_ZERO;
            err_run_r   <= ER_ZERO;
            locked_r    <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            prev_r      <= prev_s;
            match_run_r <= match_run_s;
            err_run_r   <= err_run_s;
            locked_r    <= (state_s == LOCKED);
            error_r     <= err_inc_s;
        end
    end

    sat_counter #(
        .WIDTH (ERR_WIDTH)
    ) u_err_count (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .inc   (err_inc_s),
        .clr   (i_Clear),
        .count (o_Err_Count)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_word_count (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .inc   (word_inc_s),
        .clr   (i_Clear),
        .count (o_Word_Count)
    );

    assign o_Locked = locked_r;
    assign o_Error  = error_r;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker. Two instances share the stimulus:
// index 0 unlocks after 4 consecutive errors, index 1 after 32.
module tb_prbs_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] data = 8'h00;

    logic        locked_s [2];
    logic        error_s  [2];
    logic [3:0]  errc_s   [2];
    logic [31:0] wordc_s  [2];

    int checks = 0;
    int errors = 0;

    // Reference model state (0 idle, 1 acquiring, 2 locked)
    int         m_state  [2];
    logic [7:0] m_prev   [2];
    int         m_mrun   [2];
    int         m_erun   [2];
    int         m_ec     [2];
    longint     m_wc     [2];
    bit         m_err    [2];
    bit         m_locked [2];
    int         unlock_lim [2] = '{4, 32};

    logic [7:0] gen = 8'h01;

    always #5 clk = ~clk;

    prbs_checker #(
        .NUM_BITS(8), .LOCK_COUNT(8), .UNLOCK_COUNT(4), .ERR_WIDTH(4), .CNT_WIDTH(32)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Data(data), .i_Clear(clr),
        .o_Locked(locked_s[0]), .o_Error(error_s[0]),
        .o_Err_Count(errc_s[0]), .o_Word_Count(wordc_s[0])
    );

    prbs_checker #(
        .NUM_BITS(8), .LOCK_COUNT(8), .UNLOCK_COUNT(32), .ERR_WIDTH(4), .CNT_WIDTH(32)
    ) dut_u32 (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Data(data), .i_Clear(clr),
        .o_Locked(locked_s[1]), .o_Error(error_s[1]),
        .o_Err_Count(errc_s[1]), .o_Word_Count(wordc_s[1])
    );

    // Generator sequence for an 8-bit XNOR LFSR with taps 8,6,5,4 (1-based)
    function automatic logic [7:0] gen_next(input logic [7:0] w);
        logic fb;
        fb = !(w[7] ^ w[5] ^ w[4] ^ w[3]);
        return {w[6:0], fb};
    endfunction

    // Apply one word of the checker's rules to the model of instance k
    task automatic model_step(input int k, input bit r, input bit e,
                              input logic [7:0] d, input bit c);
        logic [7:0] pred;
        bit         good;
        m_err[k] = 1'b0;
        if (r) begin
            m_state[k] = 0; m_prev[k] = 8'h00; m_mrun[k] = 0;
            m_erun[k] = 0; m_ec[k] = 0; m_wc[k] = 0;
        end else begin
            if (e) begin
                pred = gen_next(m_prev[k]);
                good = (d == pred) && (d != 8'hFF);
                if (m_state[k] == 0) begin
                    m_prev[k] = d; m_mrun[k] = 0; m_state[k] = 1;
                end else if (m_state[k] == 1) begin
                    m_mrun[k] = good ? m_mrun[k] + 1 : 0;
                    m_prev[k] = d;
                    if (m_mrun[k] == 8) begin
                        m_state[k] = 2; m_erun[k] = 0;
                    end
                end else begin
                    m_prev[k] = pred;
                    if (m_wc[k] < 64'hFFFF_FFFF) m_wc[k] = m_wc[k] + 1;
                    if (good) begin
                        m_erun[k] = 0;
                    end else begin
                        m_err[k] = 1'b1;
                        if (m_ec[k] < 15) m_ec[k] = m_ec[k] + 1;
                        m_erun[k] = m_erun[k] + 1;
                        if (m_erun[k] == unlock_lim[k]) begin
                            m_state[k] = 1; m_mrun[k] = 0; m_prev[k] = d;
                        end
                    end
                end
            end
            if (c) begin
                m_ec[k] = 0; m_wc[k] = 0;
            end
        end
        m_locked[k] = (m_state[k] == 2);
    endtask

    // Drive one clock cycle, advance the model, settle just after the edge
    task automatic cycle(input bit r, input bit e, input logic [7:0] d, input bit c);
        rst = r; en = e; data = d; clr = c;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, r, e, d, c);
        #1;
    endtask

    task automatic send_gen();
        cycle(1'b0, 1'b1, gen, 1'b0);
        gen = gen_next(gen);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({locked_s[k], error_s[k], errc_s[k], wordc_s[k]} !== 38'd0) begin
                errors++;
                $display("FAIL reset inst%0d got locked=%0b err=%0b errc=%0h wordc=%0h want all 0",
                         k, locked_s[k], error_s[k], errc_s[k], wordc_s[k]);
            end
        end
    endtask

    task automatic test_lock_acquire();
        gen = 8'h01;
        for (int w = 1; w <= 20; w++) begin
            send_gen();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (locked_s[k] !== (w >= 9) || error_s[k] !== 1'b0 || errc_s[k] !== 4'h0) begin
                    errors++;
                    $display("FAIL lock_acquire inst%0d word %0d got locked=%0b err=%0b errc=%0h want locked=%0b err=0 errc=0",
                             k, w, locked_s[k], error_s[k], errc_s[k], (w >= 9));
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (wordc_s[k] !== 32'd11) begin
                errors++;
                $display("FAIL lock_word_count inst%0d got %0d want 11", k, wordc_s[k]);
            end
        end
    endtask

    task automatic test_single_error();
        int pulses [2];
        pulses = '{0, 0};
        for (int i = 0; i < 3; i++) send_gen();
        cycle(1'b0, 1'b1, gen ^ 8'h01, 1'b0);
        gen = gen_next(gen);
        for (int k = 0; k < 2; k++) pulses[k] += error_s[k];
        for (int i = 0; i < 6; i++) begin
            send_gen();
            for (int k = 0; k < 2; k++) begin
                pulses[k] += error_s[k];
                checks++;
                if (locked_s[k] !== 1'b1 || error_s[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL single_err_after inst%0d got locked=%0b err=%0b want 1/0",
                             k, locked_s[k], error_s[k]);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (pulses[k] != 1 || errc_s[k] !== 4'h1) begin
                errors++;
                $display("FAIL single_err inst%0d got pulses=%0d errc=%0h want 1/1",
                         k, pulses[k], errc_s[k]);
            end
        end
    endtask

    task automatic test_unlock();
        int pulses [2];
        int want   [2];
        pulses = '{0, 0};
        want   = '{0, 0};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 8'hA5, 1'b0);
            gen = gen_next(gen);
            for (int k = 0; k < 2; k++) begin
                pulses[k] += error_s[k];
                want[k]   += m_err[k];
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (pulses[k] != want[k] || locked_s[k] !== m_locked[k] || errc_s[k] !== m_ec[k][3:0]) begin
                errors++;
                $display("FAIL unlock inst%0d got pulses=%0d locked=%0b errc=%0h want %0d/%0b/%0h",
                         k, pulses[k], locked_s[k], errc_s[k], want[k], m_locked[k], m_ec[k][3:0]);
            end
        end
        checks++;
        if (locked_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL unlock_drop got locked=%0b want 0", locked_s[0]);
        end
        for (int i = 0; i < 12; i++) begin
            send_gen();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (locked_s[k] !== m_locked[k]) begin
                    errors++;
                    $display("FAIL relock inst%0d word %0d got %0b want %0b",
                             k, i, locked_s[k], m_locked[k]);
                end
            end
        end
        checks++;
        if (locked_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL relock_final got %0b want 1", locked_s[0]);
        end
    endtask

    task automatic test_gaps();
        int v;
        v = 0;
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        gen = 8'h01;
        while (v < 20) begin
            send_gen();
            v++;
            checks++;
            if (locked_s[0] !== (v >= 9) || error_s[0] !== 1'b0) begin
                errors++;
                $display("FAIL gaps word %0d got locked=%0b err=%0b want %0b/0",
                         v, locked_s[0], error_s[0], (v >= 9));
            end
            if (v % 3 == 0) begin
                for (int g = 0; g < 5; g++) begin
                    cycle(1'b0, 1'b0, 8'($urandom), 1'b0);
                    checks++;
                    if (locked_s[0] !== (v >= 9) || error_s[0] !== 1'b0) begin
                        errors++;
                        $display("FAIL gaps idle after %0d got locked=%0b err=%0b", v, locked_s[0], error_s[0]);
                    end
                end
            end
        end
        checks++;
        if (wordc_s[0] !== 32'd11) begin
            errors++;
            $display("FAIL gaps_word_count got %0d want 11", wordc_s[0]);
        end
    endtask

    task automatic test_saturate_clear();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        gen = 8'h01;
        for (int i = 0; i < 10; i++) send_gen();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, gen ^ 8'h01, 1'b0);
            gen = gen_next(gen);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (error_s[k] !== 1'b1 || locked_s[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_pulse inst%0d iter %0d got err=%0b locked=%0b want 1/1",
                             k, i, error_s[k], locked_s[k]);
                end
            end
            send_gen();
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (errc_s[k] !== 4'hF) begin
                errors++;
                $display("FAIL sat_count inst%0d got %0h want f", k, errc_s[k]);
            end
        end
        cycle(1'b0, 1'b1, gen ^ 8'h01, 1'b1);
        gen = gen_next(gen);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (errc_s[k] !== 4'h0 || wordc_s[k] !== 32'd0 || error_s[k] !== 1'b1 || locked_s[k] !== 1'b1) begin
                errors++;
                $display("FAIL clear inst%0d got errc=%0h wordc=%0d err=%0b locked=%0b want 0/0/1/1",
                         k, errc_s[k], wordc_s[k], error_s[k], locked_s[k]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        send_gen();
        cycle(1'b1, 1'b1, gen, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({locked_s[k], error_s[k], errc_s[k], wordc_s[k]} !== 38'd0) begin
                errors++;
                $display("FAIL mid_reset inst%0d got locked=%0b err=%0b errc=%0h wordc=%0h want all 0",
                         k, locked_s[k], error_s[k], errc_s[k], wordc_s[k]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 8'hFF, 1'b0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (locked_s[k] !== 1'b0 || error_s[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL all_ones inst%0d word %0d got locked=%0b err=%0b want 0/0",
                             k, i, locked_s[k], error_s[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        int burst;
        bit r, e, c;
        logic [7:0] d;
        burst = 0;
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        gen = 8'h01;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 39) == 0);
            if (e && burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(3, 6);
            d = gen;
            if (e && (burst > 0 || $urandom_range(0, 9) == 0)) d = gen ^ 8'($urandom_range(1, 255));
            if (e && burst > 0) burst--;
            cycle(r, e, d, c);
            if (e) gen = gen_next(gen);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (locked_s[k] !== m_locked[k] || error_s[k] !== m_err[k] ||
                    errc_s[k] !== m_ec[k][3:0] || wordc_s[k] !== m_wc[k][31:0]) begin
                    errors++;
                    $display("FAIL random inst%0d cyc %0d got %0b/%0b/%0h/%0d want %0b/%0b/%0h/%0d",
                             k, i, locked_s[k], error_s[k], errc_s[k], wordc_s[k],
                             m_locked[k], m_err[k], m_ec[k][3:0], m_wc[k][31:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_single_error();
        test_unlock();
        test_gaps();
        test_saturate_clear();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
